conv_window_ctrl: RTL
=====================

# conv_window_ctrl

Sequencing controller for the two `lineBuffer` instances that form the 3×3 convolution window in the conv engine. It accepts the 64-bit activation word stream from the input DMA and drives each line buffer's `data_valid` and `curr_width`. For same-padding it injects the zero column and zero row the buffers need. It also tags every beat that completes a 3×3 window with its output coordinates and border-padding flags for the MAC array.

## Interface
- MAX_WIDTH, 8192: line-buffer depth in 64-bit words; must equal the `lineBuffer` MAX_WIDTH.
- DIM_W, 16: width of the height, width and channel-group configuration fields.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; latches cfg_* when idle, ignored while busy
- cfg_width  in  DIM_W  input pixels per row, W
- cfg_height  in  DIM_W  input rows, H
- cfg_cgroups  in  DIM_W  64-bit words per pixel, CG
- cfg_pad  in  1  1 = same padding (pad 1), 0 = valid convolution
- busy  out  1  frame in progress (LOAD through DONE)
- done  out  1  one-cycle completion pulse
- cfg_error  out  1  sticky config error; cleared by the next start
- in_valid  in  1  input word available
- in_ready  out  1  controller accepts an input word
- lb_data_valid  out  1  shift strobe to both line buffers and the window registers
- lb_zero  out  1  datapath muxes a zero word into the buffers in place of the input word
- lb_curr_width  out  32  line length E = (W+cfg_pad)·CG
- win_valid  out  1  window taps valid this cycle
- win_row, win_col  out  DIM_W  output-map coordinates of the window
- win_cg  out  DIM_W  channel group of the window
- pad_top, pad_bottom, pad_left, pad_right  out  1  taps on that side are padding and must be masked

## Operation
- Extended grid: Wext = W+pad, Hext = H+pad. Counters cg (0..CG-1, fastest), col (0..Wext-1), row (0..Hext-1) advance on every beat. A beat is any cycle with lb_data_valid=1.
- FSM states:
  - IDLE: on start, latch cfg, go to LOAD.
  - LOAD: compute E and register lb_curr_width. Go to ROW, or go to DONE with cfg_error=1 if any of the following holds:
    - W, H or CG is 0
    - E > MAX_WIDTH
    - cfg_pad=0 and (W<3 or H<3)
  - ROW: in_ready=1. A beat occurs when in_valid=1, with lb_zero=0. After the beat at (col=W-1, cg=CG-1), the next state is chosen in this order:
    - cfg_pad=1: RPAD
    - else row=H-1: DONE
    - else: ROW with row+1
  - RPAD: in_ready=0, lb_data_valid=1, lb_zero=1 every cycle at col=W. After cg=CG-1: if row=H-1 go to BPAD (row=H), else go to ROW with row+1.
  - BPAD: zero beats every cycle over row H, col 0..W. After col=W, cg=CG-1, go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Window emission for a beat at (row r, col c, cg g) happens when r ≥ 2−pad and c ≥ 2−pad:
  - win_row = r−2+pad
  - win_col = c−2+pad
  - win_cg = g
- Pad flags are set only when cfg_pad=1:
  - pad_top = (win_row==0)
  - pad_bottom = (win_row==H−1)
  - pad_left = (win_col==0)
  - pad_right = (win_col==W−1)
- Window counts per frame: H·W·CG windows with padding, (H−2)(W−2)·CG without.
- A frame is exactly Hext·E beats, so line-buffer write pointers return to 0 at frame end. No buffer reset is needed between frames.
- lb_curr_width is held constant from LOAD until the next start.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0. cfg_error is also cleared to 0.
- Registered outputs: in_ready, busy, done, cfg_error, lb_curr_width and all win_*/pad_*.
- Combinational outputs: lb_data_valid = (ROW & in_valid) | RPAD | BPAD, and lb_zero = RPAD | BPAD.
- Start latency: start at cycle 0 gives LOAD at cycle 1. lb_curr_width is valid at cycle 2, and in_ready rises at cycle 2 at the earliest. The line buffer registers curr_width internally, so lb_curr_width must be stable one cycle before the first beat; LOAD provides this.
- Window latency: win_* are asserted exactly one cycle after the completing beat, aligned with the registered line-buffer `o_data`.
- Done timing: done is asserted the cycle after the final beat, coincident with the final win_valid.
- Error path: done is asserted at cycle 2 with no beats.
- Backpressure: when in_valid=0 in ROW, counters hold and no window is emitted. Zero injection in RPAD/BPAD is never stalled.
- start arriving during busy has no effect.
- Asynchronous reset mid-frame returns the block to IDLE immediately, with counters and outputs zeroed. The line buffers must be reset together with this block.

## Test plan
- W=4, H=4, CG=1, pad=1, in_valid held high:
  - 16 input beats, 4 RPAD beats and 5 BPAD beats, 25 beats in total.
  - 16 win_valid; the first is (0,0) with pad_top=pad_left=1, the last is (3,3) with pad_bottom=pad_right=1.
  - lb_curr_width=5; done is asserted one cycle after beat 25.
- W=4, H=4, CG=2, pad=0: lb_curr_width=8, 32 beats with lb_zero never set, 8 windows, all pad flags 0. The first window is (0,0,cg0), emitted one cycle after the beat at row 2, col 2, cg 0.
- Pad=1 frame with in_valid toggling 1010…: window sequence and count identical to the unstalled run, and in_ready never rises during RPAD/BPAD.
- W=8192, CG=2 (E > MAX_WIDTH), and separately W=2 with pad=0: cfg_error=1, done at cycle 2, no lb_data_valid. A subsequent valid start clears cfg_error.
- rst_n asserted mid-ROW, then a new 4×4 pad frame: all outputs 0 during reset, and the new frame produces the full 16 windows correctly.
- Two back-to-back pad frames (start issued the cycle after done): the second frame matches the first beat for beat, confirming the buffer pointers wrapped to 0.

Source files
------------

// File: rtl/conv_window_ctrl_if.sv
// conv_window_ctrl_if
// Groups the control, activation-stream handshake, line-buffer strobe and window-tag
// signals of conv_window_ctrl.
//   master : frame sequencer / input DMA side (drives start, cfg_*, in_valid)
//   slave  : conv_window_ctrl (drives status, line-buffer strobes, window tags)
interface conv_window_ctrl_if #(
    parameter int unsigned DIM_W = 16
);
    logic             start;
    logic [DIM_W-1:0] cfg_width;
    logic [DIM_W-1:0] cfg_height;
    logic [DIM_W-1:0] cfg_cgroups;
    logic             cfg_pad;
    logic             busy;
    logic             done;
    logic             cfg_error;
    logic             in_valid;
    logic             in_ready;
    logic             lb_data_valid;
    logic             lb_zero;
    logic [31:0]      lb_curr_width;
    logic             win_valid;
    logic [DIM_W-1:0] win_row;
    logic [DIM_W-1:0] win_col;
    logic [DIM_W-1:0] win_cg;
    logic             pad_top;
    logic             pad_bottom;
    logic             pad_left;
    logic             pad_right;

    modport master (
        output start, cfg_width, cfg_height, cfg_cgroups, cfg_pad, in_valid,
        input  busy, done, cfg_error, in_ready, lb_data_valid, lb_zero, lb_curr_width,
               win_valid, win_row, win_col, win_cg, pad_top, pad_bottom, pad_left, pad_right
    );

    modport slave (
        input  start, cfg_width, cfg_height, cfg_cgroups, cfg_pad, in_valid,
        output busy, done, cfg_error, in_ready, lb_data_valid, lb_zero, lb_curr_width,
               win_valid, win_row, win_col, win_cg, pad_top, pad_bottom, pad_left, pad_right
    );
endinterface

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl
// Sequences the two line buffers forming a 3x3 convolution window. Accepts the 64-bit
// activation stream, injects the right zero column and bottom zero row for same padding,
// and tags each beat that completes a window with its output coordinates and border flags.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : conv_window_ctrl_if.slave (start/cfg_*, status, in_valid/in_ready,
//           lb_data_valid/lb_zero/lb_curr_width, win_*/pad_*)
module conv_window_ctrl #(
    parameter int unsigned MAX_WIDTH = 8192,
    parameter int unsigned DIM_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    conv_window_ctrl_if.slave bus
);
    localparam int unsigned LenW = 2 * DIM_W + 1;

    typedef enum logic [2:0] {StIdle, StLoad, StRow, StRpad, StBpad, StDone} state_e;

    state_e           r_state, w_state_d;
    logic [DIM_W-1:0] r_width, r_height, r_cgroups;
    logic             r_pad;
    logic [DIM_W-1:0] r_row, r_col, r_cg;
    logic [DIM_W-1:0] w_row_d, w_col_d, w_cg_d;
    logic             r_busy, r_done, r_cfg_error, r_in_ready;
    logic [31:0]      r_curr_width;
    logic             r_win_valid;
    logic [DIM_W-1:0] r_win_row, r_win_col, r_win_cg;
    logic             r_pad_top, r_pad_bottom, r_pad_left, r_pad_right;

    logic [DIM_W:0]   w_wext;
    logic [LenW-1:0]  w_ext_len;
    logic             w_cfg_bad;
    logic             w_beat;
    logic             w_cg_last, w_col_last_in, w_col_last_ext, w_row_last_in;
    logic [DIM_W:0]   w_row_sum, w_col_sum;
    logic             w_emit;
    logic [DIM_W-1:0] w_win_row, w_win_col;

    // Line length E = (W + pad) * CG, kept wide enough to detect overflow past MAX_WIDTH.
    assign w_wext    = {1'b0, r_width} + {{DIM_W{1'b0}}, r_pad};
    assign w_ext_len = LenW'(w_wext) * LenW'(r_cgroups);
    assign w_cfg_bad = (r_width == '0) || (r_height == '0) || (r_cgroups == '0) ||
                       (w_ext_len > LenW'(MAX_WIDTH)) ||
                       (!r_pad && ((r_width < DIM_W'(3)) || (r_height < DIM_W'(3))));

    assign w_cg_last      = (r_cg == r_cgroups - DIM_W'(1));
    assign w_col_last_in  = (r_col == r_width - DIM_W'(1));
    // Last column of the extended grid: the zero column W when padding, else W-1.
    assign w_col_last_ext = r_pad ? (r_col == r_width) : w_col_last_in;
    assign w_row_last_in  = (r_row == r_height - DIM_W'(1));

    assign w_beat = ((r_state == StRow) && bus.in_valid) ||
                    (r_state == StRpad) || (r_state == StBpad);

    // A beat completes a window once two rows/cols of history (one of them virtual
    // when padding) are in the buffers.
    assign w_row_sum = {1'b0, r_row} + {{DIM_W{1'b0}}, r_pad};
    assign w_col_sum = {1'b0, r_col} + {{DIM_W{1'b0}}, r_pad};
    assign w_emit    = w_beat && (w_row_sum >= (DIM_W + 1)'(2)) &&
                       (w_col_sum >= (DIM_W + 1)'(2));
    assign w_win_row = w_row_sum[DIM_W-1:0] - DIM_W'(2);
    assign w_win_col = w_col_sum[DIM_W-1:0] - DIM_W'(2);

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: if (bus.start) w_state_d = StLoad;
            StLoad: w_state_d = w_cfg_bad ? StDone : StRow;
            StRow: begin
                if (bus.in_valid && w_cg_last && w_col_last_in) begin
                    if (r_pad)              w_state_d = StRpad;
                    else if (w_row_last_in) w_state_d = StDone;
                end
            end
            StRpad: if (w_cg_last) w_state_d = w_row_last_in ? StBpad : StRow;
            StBpad: if (w_cg_last && w_col_last_ext) w_state_d = StDone;
            StDone: w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Extended-grid counters: cg fastest, then col, then row.
    always_comb begin
        w_cg_d  = r_cg;
        w_col_d = r_col;
        w_row_d = r_row;
        if ((r_state == StLoad) || (r_state == StDone)) begin
            w_cg_d  = '0;
            w_col_d = '0;
            w_row_d = '0;
        end else if (w_beat) begin
            if (w_cg_last) begin
                w_cg_d = '0;
                if (w_col_last_ext) begin
                    w_col_d = '0;
                    w_row_d = r_row + DIM_W'(1);
                end else begin
                    w_col_d = r_col + DIM_W'(1);
                end
            end else begin
                w_cg_d = r_cg + DIM_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_width      <= '0;
            r_height     <= '0;
            r_cgroups    <= '0;
            r_pad        <= 1'b0;
            r_row        <= '0;
            r_col        <= '0;
            r_cg         <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cfg_error  <= 1'b0;
            r_in_ready   <= 1'b0;
            r_curr_width <= '0;
            r_win_valid  <= 1'b0;
            r_win_row    <= '0;
            r_win_col    <= '0;
            r_win_cg     <= '0;
            r_pad_top    <= 1'b0;
            r_pad_bottom <= 1'b0;
            r_pad_left   <= 1'b0;
            r_pad_right  <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_row      <= w_row_d;
            r_col      <= w_col_d;
            r_cg       <= w_cg_d;
            r_busy     <= (w_state_d != StIdle);
            r_done     <= (w_state_d == StDone);
            r_in_ready <= (w_state_d == StRow);
            if ((r_state == StIdle) && bus.start) begin
                r_width     <= bus.cfg_width;
                r_height    <= bus.cfg_height;
                r_cgroups   <= bus.cfg_cgroups;
                r_pad       <= bus.cfg_pad;
                r_cfg_error <= 1'b0;
            end
            if (r_state == StLoad) begin
                r_curr_width <= w_ext_len[31:0];
                if (w_cfg_bad) r_cfg_error <= 1'b1;
            end
            r_win_valid <= w_emit;
            if (w_emit) begin
                r_win_row    <= w_win_row;
                r_win_col    <= w_win_col;
                r_win_cg     <= r_cg;
                r_pad_top    <= r_pad && (w_win_row == '0);
                r_pad_bottom <= r_pad && (w_win_row == r_height - DIM_W'(1));
                r_pad_left   <= r_pad && (w_win_col == '0);
                r_pad_right  <= r_pad && (w_win_col == r_width - DIM_W'(1));
            end
        end
    end

    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.cfg_error     = r_cfg_error;
    assign bus.in_ready      = r_in_ready;
    assign bus.lb_data_valid = w_beat;
    assign bus.lb_zero       = (r_state == StRpad) || (r_state == StBpad);
    assign bus.lb_curr_width = r_curr_width;
    assign bus.win_valid     = r_win_valid;
    assign bus.win_row       = r_win_row;
    assign bus.win_col       = r_win_col;
    assign bus.win_cg        = r_win_cg;
    assign bus.pad_top       = r_pad_top;
    assign bus.pad_bottom    = r_pad_bottom;
    assign bus.pad_left      = r_pad_left;
    assign bus.pad_right     = r_pad_right;
endmodule
